apu_frame_sequencer: RTL and testbench
======================================

# apu_frame_sequencer

Frame counter and sequencer for the NES APU (tt_um_fjpolo_nes_apu). Counts APU ticks and emits one-clock quarter-frame and half-frame strobes that clock the envelope, linear-counter, length-counter and sweep units of the pulse, triangle and noise channels. Implements the $4017 mode and IRQ-inhibit controls and the frame IRQ flag read and cleared through $4015. Sits between the CPU register decoder and the channel datapaths.

## Interface
- CNT_W, 15: tick counter width.
- STEP1, 3728: tick count of the first quarter frame.
- STEP2, 7456: tick count of the second step.
- STEP3, 11185: tick count of the third step.
- STEP4, 14914: tick count of the fourth step (end of sequence in 4-step mode).
- STEP5, 18640: tick count of the fifth step (end of sequence in 5-step mode).
- Parameter legality: 0 < STEP1 < STEP2 < STEP3 < STEP4 < STEP5 < 2^CNT_W.

- clk  in  1  system clock, the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- apu_tick  in  1  one-clk enable at the APU cycle rate (CPU/2).
- wr_4017  in  1  one-clk write strobe for $4017.
- wr_data  in  8  write data; bit 7 = mode (0 = 4-step, 1 = 5-step); bit 6 = IRQ inhibit.
- rd_4015  in  1  one-clk status-read strobe; clears the frame IRQ.
- quarter_frame  out  1  one-clk quarter-frame strobe.
- half_frame  out  1  one-clk half-frame strobe (always coincident with quarter_frame).
- frame_irq  out  1  frame interrupt flag, level.
- mode5  out  1  current mode bit.

## Operation
- State: cnt[CNT_W-1:0], mode5, inhibit, frame_irq, pending (counter restart requested).
- All outputs and state are registered. Reset values are 0 for all of them, including quarter_frame and half_frame.
- On each apu_tick with pending = 0, compute n = cnt + 1 and act on n:
  - 4-step mode (mode5 = 0):
    - n = STEP1 or STEP3: pulse quarter_frame.
    - n = STEP2: pulse quarter_frame and half_frame.
    - n = STEP4: pulse quarter_frame and half_frame; set frame_irq if inhibit = 0; cnt ← 0.
    - Otherwise cnt ← n.
  - 5-step mode (mode5 = 1):
    - STEP1 and STEP3 give quarter_frame only.
    - STEP2 gives quarter_frame and half_frame.
    - STEP4 gives no output; cnt continues.
    - n = STEP5: pulse quarter_frame and half_frame; cnt ← 0.
    - frame_irq is never set in 5-step mode.
- On an apu_tick with pending = 1: cnt ← 0 and pending ← 0. If mode5 = 1, pulse quarter_frame and half_frame. No step comparison runs on this tick.
- $4017 write, in the same clk as wr_4017:
  - mode5 ← wr_data[7].
  - inhibit ← wr_data[6].
  - pending ← 1.
  - If wr_data[6] = 1, frame_irq ← 0 on the next clk.
- rd_4015: frame_irq ← 0 on the next clk.
- Ticks arriving while cnt is in an out-of-sequence state (impossible with legal parameters) are not specially handled.

## Timing
- Strobes assert in the clk after the clock edge that samples apu_tick. They are high for exactly one clk, regardless of the apu_tick duty cycle.
- With no apu_tick, state holds and strobes stay 0.
- Write in the same clk as apu_tick: that tick is processed with the old mode5/inhibit and normal counting. The restart takes effect on the next apu_tick.
- A second write before the restart is applied: last write wins. pending stays 1 and only one restart occurs.
- The IRQ set condition (STEP4 in 4-step mode, inhibit = 0) in the same clk as rd_4015: set wins and frame_irq = 1.
- The IRQ set condition in the same clk as a write with bit 6 = 1: clear wins, because the set is gated by the new inhibit value.
- rst_n low mid-sequence: on the next clk edge all state returns to reset values. Any pending restart is dropped and no strobe is emitted.
- Latency from apu_tick to strobe is 1 clk. Latency from rd_4015 or write to frame_irq change is 1 clk.

## Test plan
Bench parameters: STEP1..5 = 4, 8, 12, 16, 20; apu_tick held high.
- 4-step free run from reset, 32 ticks:
  - quarter_frame pulses after ticks 4, 8, 12, 16, 20, 24, 28, 32.
  - half_frame pulses after ticks 8, 16, 24, 32.
  - frame_irq rises after tick 16 and stays 1.
- IRQ clear: after frame_irq = 1, pulse rd_4015 → frame_irq = 0 next clk, and it re-asserts after tick 32. Also pulse rd_4015 in the clk of tick 32 → frame_irq remains 1 (set wins).
- Write 0x80 (5-step):
  - The next tick restarts the counter with quarter_frame and half_frame pulses.
  - Then quarter_frame pulses at n = 4, 8, 12, 20; half_frame at n = 8, 20.
  - Nothing at n = 16; frame_irq stays 0 for 60 ticks.
- Write 0x40 with frame_irq = 1 → frame_irq = 0 next clk. The counter restarts without a strobe, and 40 further ticks give no IRQ.
- apu_tick every 3rd clk, 4-step mode:
  - Strobes are one clk wide and lag the sampled tick by 1 clk.
  - The first quarter_frame follows the 4th tick.
- Reset mid-sequence at n = 10 (rst_n low for 1 clk):
  - All outputs are 0 the next clk.
  - The following quarter_frame comes exactly 4 ticks after rst_n returns high.

Source files
------------

// File: rtl/apu_frame_sequencer_if.sv
// Register/strobe bundle between the CPU register decoder and the APU frame sequencer.
// The master side drives the tick and register accesses; the slave side returns the frame strobes.
interface apu_frame_sequencer_if;
  logic       apu_tick;
  logic       wr_4017;
  logic [7:0] wr_data;
  logic       rd_4015;
  logic       quarter_frame;
  logic       half_frame;
  logic       frame_irq;
  logic       mode5;

  modport master (
    output apu_tick, wr_4017, wr_data, rd_4015,
    input  quarter_frame, half_frame, frame_irq, mode5
  );

  modport slave (
    input  apu_tick, wr_4017, wr_data, rd_4015,
    output quarter_frame, half_frame, frame_irq, mode5
  );
endinterface

// File: rtl/apu_frame_sequencer.sv
// NES APU frame counter: counts APU ticks and emits quarter/half-frame strobes,
// with $4017 mode/inhibit control and the frame IRQ flag cleared through $4015.
module apu_frame_sequencer #(
  parameter int unsigned CNT_W = 15,
  parameter int unsigned STEP1 = 3728,
  parameter int unsigned STEP2 = 7456,
  parameter int unsigned STEP3 = 11185,
  parameter int unsigned STEP4 = 14914,
  parameter int unsigned STEP5 = 18640
) (
  input  logic                   clk,
  input  logic                   rst_n,
  apu_frame_sequencer_if.slave   bus
);

  localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
  localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);

  logic [CNT_W-1:0] cnt, cnt_nxt, n;
  logic             mode5_r, mode5_nxt;
  logic             inhibit, inhibit_nxt;
  logic             irq, irq_nxt;
  logic             pending, pending_nxt;
  logic             qf, qf_nxt;
  logic             hf, hf_nxt;
  logic             irq_set;
  logic             wr_inhibit;
  logic             unused_wr_bits;

  assign unused_wr_bits = ^bus.wr_data[5:0];
  assign n              = cnt + 1'b1;
  assign wr_inhibit     = bus.wr_4017 & bus.wr_data[6];

  always_comb begin
    cnt_nxt     = cnt;
    mode5_nxt   = mode5_r;
    inhibit_nxt = inhibit;
    irq_nxt     = irq;
    pending_nxt = pending;
    qf_nxt      = 1'b0;
    hf_nxt      = 1'b0;
    irq_set     = 1'b0;

    // The tick is always evaluated with the pre-write mode/inhibit values.
    if (bus.apu_tick) begin
      if (pending) begin
        cnt_nxt     = '0;
        pending_nxt = 1'b0;
        qf_nxt      = mode5_r;
        hf_nxt      = mode5_r;
      end else begin
        cnt_nxt = n;
        if (n == S1 || n == S3) begin
          qf_nxt = 1'b1;
        end else if (n == S2) begin
          qf_nxt = 1'b1;
          hf_nxt = 1'b1;
        end else if (n == S4 && !mode5_r) begin
          qf_nxt  = 1'b1;
          hf_nxt  = 1'b1;
          irq_set = !inhibit;
          cnt_nxt = '0;
        end else if (n == S5 && mode5_r) begin
          qf_nxt  = 1'b1;
          hf_nxt  = 1'b1;
          cnt_nxt = '0;
        end
      end
    end

    if (bus.wr_4017) begin
      mode5_nxt   = bus.wr_data[7];
      inhibit_nxt = bus.wr_data[6];
      pending_nxt = 1'b1;
    end

    // Set beats a status read, but a write that raises inhibit beats the set.
    if (irq_set && !wr_inhibit) begin
      irq_nxt = 1'b1;
    end else if (bus.rd_4015 || wr_inhibit) begin
      irq_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      mode5_r <= 1'b0;
      inhibit <= 1'b0;
      irq     <= 1'b0;
      pending <= 1'b0;
      qf      <= 1'b0;
      hf      <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      mode5_r <= mode5_nxt;
      inhibit <= inhibit_nxt;
      irq     <= irq_nxt;
      pending <= pending_nxt;
      qf      <= qf_nxt;
      hf      <= hf_nxt;
    end
  end

  assign bus.quarter_frame = qf;
  assign bus.half_frame    = hf;
  assign bus.frame_irq     = irq;
  assign bus.mode5         = mode5_r;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Self-checking bench for apu_frame_sequencer with shortened step counts (4/8/12/16/20).
// Table vectors, hand-written corner sequences and random traffic against a position-based model.
module tb_apu_frame_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apu_frame_sequencer_if bus();

  apu_frame_sequencer #(
    .CNT_W(15),
    .STEP1(4),
    .STEP2(8),
    .STEP3(12),
    .STEP4(16),
    .STEP5(20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic t;
    logic r;
    logic q;
    logic h;
    logic irq;
  } vec_t;

  vec_t tbl[33];

  int vectors = 0;
  int miscompares = 0;

  // Model: position within the current sequence plus register copies.
  int   m_pos;
  logic m_mode, m_inh, m_irq, m_pend, m_q, m_h;

  task automatic chk(input string name, input int act, input int exp);
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      miscompares++;
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_mode = 0; m_inh = 0; m_irq = 0; m_pend = 0; m_q = 0; m_h = 0;
  endtask

  task automatic model_step(input logic t, input logic w, input logic [7:0] d, input logic r);
    int   n, period;
    logic set;
    m_q = 0; m_h = 0; set = 0;
    if (t) begin
      if (m_pend) begin
        m_pos = 0; m_pend = 0; m_q = m_mode; m_h = m_mode;
      end else begin
        n      = m_pos + 1;
        period = m_mode ? 20 : 16;
        m_q    = (n % 4 == 0) && !(m_mode && n == 16);
        m_h    = (n == 8) || (n == period);
        set    = !m_mode && (n == 16) && !m_inh;
        m_pos  = (n == period) ? 0 : n;
      end
    end
    if (w) begin
      m_mode = d[7]; m_inh = d[6]; m_pend = 1;
    end
    if (set && !(w && d[6])) m_irq = 1;
    else if (r || (w && d[6])) m_irq = 0;
  endtask

  task automatic cyc(input logic t, input logic w, input logic [7:0] d, input logic r);
    bus.apu_tick = t; bus.wr_4017 = w; bus.wr_data = d; bus.rd_4015 = r;
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else model_step(t, w, d, r);
    vectors++;
    chk("quarter_frame", int'(bus.quarter_frame), int'(m_q));
    chk("half_frame", int'(bus.half_frame), int'(m_h));
    chk("frame_irq", int'(bus.frame_irq), int'(m_irq));
    chk("mode5", int'(bus.mode5), int'(m_mode));
    bus.apu_tick = 0; bus.wr_4017 = 0; bus.wr_data = '0; bus.rd_4015 = 0;
  endtask

  task automatic tick();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(1'b0, 1'b1, d, 1'b0);
  endtask

  initial begin
    int qc, hc, seen, tk, first_q;
    logic t;

    bus.apu_tick = 0; bus.wr_4017 = 0; bus.wr_data = '0; bus.rd_4015 = 0;
    model_reset();

    // Reset state
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    chk("reset_q", int'(bus.quarter_frame), 0);
    chk("reset_h", int'(bus.half_frame), 0);
    chk("reset_irq", int'(bus.frame_irq), 0);
    chk("reset_mode5", int'(bus.mode5), 0);
    rst_n = 1;

    // 4-step free run with reads at tick 20 (clears) and tick 32 (set wins)
    for (int i = 0; i < 33; i++) begin
      tbl[i].t   = (i != 0);
      tbl[i].r   = (i == 20) || (i == 32);
      tbl[i].q   = (i != 0) && (i % 4 == 0);
      tbl[i].h   = (i != 0) && (i % 8 == 0);
      tbl[i].irq = (i >= 16 && i < 20) || (i == 32);
    end
    for (int i = 0; i < 33; i++) begin
      cyc(tbl[i].t, 1'b0, 8'h00, tbl[i].r);
      chk($sformatf("tbl%0d_q", i), int'(bus.quarter_frame), int'(tbl[i].q));
      chk($sformatf("tbl%0d_h", i), int'(bus.half_frame), int'(tbl[i].h));
      chk($sformatf("tbl%0d_irq", i), int'(bus.frame_irq), int'(tbl[i].irq));
    end

    // 5-step mode
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rd_clear", int'(bus.frame_irq), 0);
    wr(8'h80);
    chk("mode5_set", int'(bus.mode5), 1);
    tick();
    chk("m5_restart_q", int'(bus.quarter_frame), 1);
    chk("m5_restart_h", int'(bus.half_frame), 1);
    qc = 0; hc = 0; seen = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k <= 20) begin
        qc += int'(bus.quarter_frame);
        hc += int'(bus.half_frame);
      end
      if (k == 16) chk("m5_n16_q", int'(bus.quarter_frame), 0);
      if (k == 20) chk("m5_n20_h", int'(bus.half_frame), 1);
      seen |= int'(bus.frame_irq);
    end
    chk("m5_q_count", qc, 4);
    chk("m5_h_count", hc, 2);
    chk("m5_no_irq", seen, 0);

    // Inhibit write clears IRQ, restart without strobe, no further IRQ
    wr(8'h00);
    tick();
    chk("m4_restart_q", int'(bus.quarter_frame), 0);
    repeat (16) tick();
    chk("irq_before_inh", int'(bus.frame_irq), 1);
    wr(8'h40);
    chk("inh_clear", int'(bus.frame_irq), 0);
    tick();
    chk("inh_restart_q", int'(bus.quarter_frame), 0);
    chk("inh_restart_h", int'(bus.half_frame), 0);
    seen = 0;
    repeat (40) begin
      tick();
      seen |= int'(bus.frame_irq);
    end
    chk("inh_no_irq", seen, 0);

    // Write in the same clk as a tick: tick uses old mode, restart on next tick
    wr(8'h00);
    tick();
    repeat (3) tick();
    cyc(1'b1, 1'b1, 8'h80, 1'b0);
    chk("wr_tick_q", int'(bus.quarter_frame), 1);
    chk("wr_tick_h", int'(bus.half_frame), 0);
    tick();
    chk("wr_tick_restart_h", int'(bus.half_frame), 1);

    // Two writes before restart: last wins, single restart
    wr(8'hC0);
    wr(8'h00);
    tick();
    chk("dbl_wr_q", int'(bus.quarter_frame), 0);
    chk("dbl_wr_mode", int'(bus.mode5), 0);
    tk = 0;
    for (int k = 1; k <= 8 && tk == 0; k++) begin
      tick();
      if (bus.quarter_frame) tk = k;
    end
    chk("dbl_wr_first_q", tk, 4);

    // IRQ set in the same clk as an inhibiting write: clear wins
    wr(8'h00);
    tick();
    repeat (15) tick();
    cyc(1'b1, 1'b1, 8'h40, 1'b0);
    chk("set_vs_inh_irq", int'(bus.frame_irq), 0);
    chk("set_vs_inh_q", int'(bus.quarter_frame), 1);

    // Tick every third clk
    wr(8'h00);
    tick();
    tk = 0; first_q = -1;
    for (int i = 0; i < 30; i++) begin
      t = (i % 3 == 0);
      cyc(t, 1'b0, 8'h00, 1'b0);
      if (t) tk++;
      if (bus.quarter_frame && first_q < 0) begin
        first_q = tk;
        chk("sparse_lag", int'(t), 1);
      end
    end
    chk("sparse_first_q", first_q, 4);

    // Reset mid-sequence
    wr(8'h80);
    tick();
    repeat (10) tick();
    rst_n = 0;
    cyc(1'b1, 1'b1, 8'hC0, 1'b1);
    chk("midrst_q", int'(bus.quarter_frame), 0);
    chk("midrst_h", int'(bus.half_frame), 0);
    chk("midrst_mode", int'(bus.mode5), 0);
    rst_n = 1;
    tk = 0;
    for (int k = 1; k <= 10 && tk == 0; k++) begin
      tick();
      if (bus.quarter_frame) tk = k;
    end
    chk("midrst_first_q", tk, 4);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
          8'($urandom), 1'($urandom_range(0, 29) == 0));
      rst_n = 1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
